lea_key_schedule: RTL

- Encryption key schedule for LEA-128, directly downstream of the LEA key-constant generator.
- Consumes the delta constants E0..E3 and a 128-bit user key.
- Produces the 24 round keys RK_0..RK_23, one per valid/ready handshake, for the round-function datapath.
- Iterative: one round key is computed per accepted handshake, so no 24-entry key RAM is needed.

---
 rtl/lea_pkg.sv | 26 ++
 rtl/lea_key_schedule_if.sv | 28 ++
 rtl/lea_ks_round.sv | 23 ++
 rtl/lea_key_schedule.sv | 122 ++++++++++++
 4 files changed

// File: rtl/lea_pkg.sv
// Shared LEA types and helpers: word/round-key types, FSM state encoding, rotate and key packing.
package lea_pkg;

   localparam int LEA_ROUNDS_128 = 24;

   typedef logic [31:0]  word_t;
   typedef logic [191:0] rk_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OUT  = 1'b1
   } ks_state_t;

   // Rotate by doubling the word, so an amount of 0 needs no special case.
   function automatic word_t rol32(input word_t x, input logic [4:0] n);
      logic [63:0] dbl;
      dbl = {x, x} << n;
      return dbl[63:32];
   endfunction

   // Round key word order (LSB first): T0, T1, T2, T1, T3, T1.
   function automatic rk_t make_rk(input word_t t0, input word_t t1, input word_t t2, input word_t t3);
      return {t1, t3, t1, t2, t1, t0};
   endfunction

endpackage

// File: rtl/lea_key_schedule_if.sv
// Key-schedule handshake bundle: run request, key/delta inputs and the round-key stream.
interface lea_key_schedule_if;
   import lea_pkg::*;

   logic         start;
   logic [127:0] key;
   word_t        E0;
   word_t        E1;
   word_t        E2;
   word_t        E3;
   logic         rk_ready;
   logic         busy;
   logic         rk_valid;
   rk_t          rk;
   logic [4:0]   rk_idx;
   logic         done;

   modport master (
      output start, key, E0, E1, E2, E3, rk_ready,
      input  busy, rk_valid, rk, rk_idx, done
   );

   modport slave (
      input  start, key, E0, E1, E2, E3, rk_ready,
      output busy, rk_valid, rk, rk_idx, done
   );

endinterface

// File: rtl/lea_ks_round.sv
// One LEA-128 key-schedule round: adds rotated delta to each T word, then applies the fixed rotation.
module lea_ks_round
   import lea_pkg::*;
(
   input  word_t      t0,
   input  word_t      t1,
   input  word_t      t2,
   input  word_t      t3,
   input  logic [4:0] idx,
   input  word_t      d,
   output word_t      t0_n,
   output word_t      t1_n,
   output word_t      t2_n,
   output word_t      t3_n
);

   // idx+k stays below 32 for every valid round, and 5-bit wrap gives mod 32 anyway.
   assign t0_n = rol32(t0 + rol32(d, idx),         5'd1);
   assign t1_n = rol32(t1 + rol32(d, idx + 5'd1),  5'd3);
   assign t2_n = rol32(t2 + rol32(d, idx + 5'd2),  5'd6);
   assign t3_n = rol32(t3 + rol32(d, idx + 5'd3),  5'd11);

endmodule

// File: rtl/lea_key_schedule.sv
// Iterative LEA-128 key schedule: one round key per accepted handshake, no key RAM.
//   state   | meaning
//   ST_IDLE | waiting for start; round 0 is computed from the key input
//   ST_OUT  | rk holds RK_idx; next round advances on rk_ready
module lea_key_schedule
   import lea_pkg::*;
#(
   parameter int ROUNDS = LEA_ROUNDS_128
) (
   input logic              clk,
   input logic              rst,
   lea_key_schedule_if.slave ks
);

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

   ks_state_t  state;
   word_t      t0_q, t1_q, t2_q, t3_q;
   word_t      r_t0, r_t1, r_t2, r_t3;
   word_t      t0_n, t1_n, t2_n, t3_n;
   word_t      d;
   logic [4:0] idx_q;
   logic [4:0] round_idx;
   rk_t        rk_q;
   logic       valid_q;
   logic       busy_q;
   logic       done_q;

   // Round inputs come from the key in IDLE, from the T registers otherwise.
   always_comb begin
      r_t0      = t0_q;
      r_t1      = t1_q;
      r_t2      = t2_q;
      r_t3      = t3_q;
      round_idx = idx_q + 5'd1;
      if (state == ST_IDLE) begin
         r_t0      = ks.key[31:0];
         r_t1      = ks.key[63:32];
         r_t2      = ks.key[95:64];
         r_t3      = ks.key[127:96];
         round_idx = 5'd0;
      end
      case (round_idx[1:0])
         2'd0:    d = ks.E0;
         2'd1:    d = ks.E1;
         2'd2:    d = ks.E2;
         default: d = ks.E3;
      endcase
   end

   lea_ks_round u_round (
      .t0   (r_t0),
      .t1   (r_t1),
      .t2   (r_t2),
      .t3   (r_t3),
      .idx  (round_idx),
      .d    (d),
      .t0_n (t0_n),
      .t1_n (t1_n),
      .t2_n (t2_n),
      .t3_n (t3_n)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         t0_q    <= '0;
         t1_q    <= '0;
         t2_q    <= '0;
         t3_q    <= '0;
         idx_q   <= '0;
         rk_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ks.start) begin
                  t0_q    <= t0_n;
                  t1_q    <= t1_n;
                  t2_q    <= t2_n;
                  t3_q    <= t3_n;
                  rk_q    <= make_rk(t0_n, t1_n, t2_n, t3_n);
                  idx_q   <= 5'd0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (ks.rk_ready) begin
                  if (idx_q == LAST_IDX) begin
                     // rk and T keep their final values after the run.
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     idx_q   <= 5'd0;
                     state   <= ST_IDLE;
                  end else begin
                     t0_q  <= t0_n;
                     t1_q  <= t1_n;
                     t2_q  <= t2_n;
                     t3_q  <= t3_n;
                     rk_q  <= make_rk(t0_n, t1_n, t2_n, t3_n);
                     idx_q <= round_idx;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ks.rk       = rk_q;
   assign ks.rk_idx   = idx_q;
   assign ks.rk_valid = valid_q;
   assign ks.busy     = busy_q;
   assign ks.done     = done_q;

endmodule
